// File: rtl/qspi_mem_ctrl.sv
// Quad-SPI word read/write controller for the shared RAM/ROM bus; sclk = clk/2, outputs registered.
// Request accepted in IDLE only; busy covers accept through ack, ROM writes complete without bus activity.
module qspi_mem_ctrl #(
  parameter int         DUMMY  = 4,
  parameter logic [7:0] RD_CMD = 8'hEB,
  parameter logic [7:0] WR_CMD = 8'h38
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic        rom_sel,
  input  logic [23:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        ram_csb,
  output logic        rom_csb,
  output logic        sclk,
  output logic [3:0]  io_out,
  output logic [3:0]  io_oe,
  input  logic [3:0]  io_in
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE} state_t;

  localparam logic [3:0] DUMMY_LAST = 4'(DUMMY - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [7:0]  cmd_q, cmd_d;
  logic [23:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [27:0] rsh_q, rsh_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        ram_csb_q, ram_csb_d;
  logic        rom_csb_q, rom_csb_d;
  logic        sclk_q, sclk_d;
  logic [3:0]  io_out_q, io_out_d;
  logic [3:0]  io_oe_q, io_oe_d;
  logic [7:0]  cmd_byte;
  logic        go_data, go_done;

  assign cmd_byte = we ? WR_CMD : RD_CMD;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    cmd_d     = cmd_q;
    addr_d    = addr_q;
    wd_d      = wd_q;
    rsh_d     = rsh_q;
    rdata_d   = rdata_q;
    ack_d     = 1'b0;
    busy_d    = busy_q;
    ram_csb_d = ram_csb_q;
    rom_csb_d = rom_csb_q;
    sclk_d    = sclk_q;
    io_out_d  = io_out_q;
    io_oe_d   = io_oe_q;
    go_data   = 1'b0;
    go_done   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          we_d   = we;
          addr_d = addr;
          wd_d   = wdata;
          busy_d = 1'b1;
          cnt_d  = '0;
          if (we && rom_sel) begin
            state_d = S_DONE;
            ack_d   = 1'b1;
          end else begin
            state_d   = S_CMD;
            ram_csb_d = rom_sel;
            rom_csb_d = ~rom_sel;
            io_out_d  = {3'b000, cmd_byte[7]};
            cmd_d     = {cmd_byte[6:0], 1'b0};
            io_oe_d   = 4'b0001;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        if (!sclk_q) begin
          sclk_d = 1'b1;
        end else begin
          // End of the high phase: advance to the next sclk period.
          sclk_d = 1'b0;
          cnt_d  = cnt_q + 4'd1;
          case (state_q)
            S_CMD: begin
              if (cnt_q == 4'd7) begin
                state_d  = S_ADDR;
                cnt_d    = '0;
                io_out_d = addr_q[23:20];
                addr_d   = {addr_q[19:0], 4'h0};
                io_oe_d  = 4'hF;
              end else begin
                io_out_d = {3'b000, cmd_q[7]};
                cmd_d    = {cmd_q[6:0], 1'b0};
              end
            end
            S_ADDR: begin
              if (cnt_q == 4'd5) begin
                if (!we_q && DUMMY != 0) begin
                  state_d  = S_DUMMY;
                  cnt_d    = '0;
                  io_out_d = 4'h0;
                  io_oe_d  = 4'h0;
                end else begin
                  go_data = 1'b1;
                end
              end else begin
                io_out_d = addr_q[23:20];
                addr_d   = {addr_q[19:0], 4'h0};
              end
            end
            S_DUMMY: begin
              if (cnt_q == DUMMY_LAST) go_data = 1'b1;
            end
            S_DATA: begin
              if (!we_q) rsh_d = {rsh_q[23:0], io_in};
              if (cnt_q == 4'd7) begin
                go_done = 1'b1;
              end else if (we_q) begin
                io_out_d = wd_q[31:28];
                wd_d     = {wd_q[27:0], 4'h0};
              end
            end
            default: ;
          endcase
        end
      end
    endcase

    if (go_data) begin
      state_d = S_DATA;
      cnt_d   = '0;
      if (we_q) begin
        io_out_d = wd_q[31:28];
        wd_d     = {wd_q[27:0], 4'h0};
        io_oe_d  = 4'hF;
      end else begin
        io_out_d = 4'h0;
        io_oe_d  = 4'h0;
      end
    end

    if (go_done) begin
      state_d   = S_DONE;
      ram_csb_d = 1'b1;
      rom_csb_d = 1'b1;
      io_out_d  = 4'h0;
      io_oe_d   = 4'h0;
      ack_d     = 1'b1;
      if (!we_q) rdata_d = {rsh_q[27:0], io_in};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      cmd_q     <= '0;
      addr_q    <= '0;
      wd_q      <= '0;
      rsh_q     <= '0;
      rdata_q   <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      ram_csb_q <= 1'b1;
      rom_csb_q <= 1'b1;
      sclk_q    <= 1'b0;
      io_out_q  <= '0;
      io_oe_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      we_q      <= we_d;
      cmd_q     <= cmd_d;
      addr_q    <= addr_d;
      wd_q      <= wd_d;
      rsh_q     <= rsh_d;
      rdata_q   <= rdata_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      ram_csb_q <= ram_csb_d;
      rom_csb_q <= rom_csb_d;
      sclk_q    <= sclk_d;
      io_out_q  <= io_out_d;
      io_oe_q   <= io_oe_d;
    end
  end

  assign rdata   = rdata_q;
  assign ack     = ack_q;
  assign busy    = busy_q;
  assign ram_csb = ram_csb_q;
  assign rom_csb = rom_csb_q;
  assign sclk    = sclk_q;
  assign io_out  = io_out_q;
  assign io_oe   = io_oe_q;

endmodule

// File: tb/tb_qspi_mem_ctrl.sv
// Bench for qspi_mem_ctrl: QSPI RAM/ROM slave model, transaction table and scoreboard of expected acks.
module tb_qspi_mem_ctrl;

  localparam int LAT_RD = 1 + 2 * (22 + 4);
  localparam int LAT_WR = 1 + 2 * 22;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req = 1'b0;
  logic        we = 1'b0;
  logic        rom_sel = 1'b0;
  logic [23:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        ack, busy, ram_csb, rom_csb, sclk;
  logic [3:0]  io_out, io_oe;
  logic [3:0]  io_in = 4'h0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  qspi_mem_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .rom_sel(rom_sel),
    .addr(addr), .wdata(wdata), .rdata(rdata), .ack(ack), .busy(busy),
    .ram_csb(ram_csb), .rom_csb(rom_csb), .sclk(sclk),
    .io_out(io_out), .io_oe(io_oe), .io_in(io_in)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model: decodes each rising sclk seen at the falling clk edge.
  logic [31:0] ram_mem [256];
  logic [31:0] rom_mem [256];
  int          n = 0;
  logic [7:0]  cmd_cap = '0;
  logic [23:0] addr_cap = '0;
  logic [31:0] wd_cap = '0;
  logic [31:0] rd_word = '0;
  int          dummy_z = 0;
  int          oe_err = 0;
  bit          saw_ram = 0;
  bit          saw_rom = 0;
  logic        prev_sclk = 1'b0;

  always @(negedge clk) begin
    if (ram_csb && rom_csb) begin
      n = 0;
    end else if (sclk && !prev_sclk) begin
      if (!ram_csb) saw_ram = 1;
      if (!rom_csb) saw_rom = 1;
      if (n < 8) begin
        cmd_cap = {cmd_cap[6:0], io_out[0]};
        if (io_oe !== 4'b0001) oe_err++;
      end else if (n < 14) begin
        addr_cap = {addr_cap[19:0], io_out};
        if (io_oe !== 4'hF) oe_err++;
        if (n == 13) rd_word = !rom_csb ? rom_mem[addr_cap[9:2]] : ram_mem[addr_cap[9:2]];
      end else if (cmd_cap == 8'h38) begin
        if (n < 22) begin
          wd_cap = {wd_cap[27:0], io_out};
          if (io_oe !== 4'hF) oe_err++;
          if (n == 21 && !ram_csb) ram_mem[addr_cap[9:2]] = wd_cap;
        end
      end else begin
        if (io_oe !== 4'h0) oe_err++;
        if (n < 18) begin
          dummy_z++;
        end else if (n < 26) begin
          io_in = rd_word[31:28];
          rd_word = {rd_word[27:0], 4'h0};
        end
      end
      n++;
    end
    prev_sclk = sclk;
  end

  // Scoreboard and bus-level invariant monitor.
  typedef struct {
    logic [31:0] rd;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int   cyc = 0;
  int   t_acc = 0;
  int   inv_err = 0;
  int   idle_run = 0;
  int   last_gap = 0;
  int   acks = 0;
  logic prev_busy = 1'b0;
  logic prev_ack = 1'b0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (!ram_csb && !rom_csb) inv_err++;
      if (io_oe != 4'h0 && ram_csb && rom_csb) inv_err++;
      if (sclk && ram_csb && rom_csb) inv_err++;
      if (ack && prev_ack) inv_err++;
      if (ack && !busy) inv_err++;
    end
    if (busy && !prev_busy) t_acc = cyc;
    if (!busy) begin
      idle_run++;
    end else if (idle_run > 0) begin
      last_gap = idle_run;
      idle_run = 0;
    end
    if (ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 1, 0);
      end else begin
        e = sb.pop_front();
        check("ack_latency", cyc - t_acc + 1, e.lat);
        check("rdata", rdata, e.rd);
        acks++;
      end
    end
    prev_busy = busy;
    prev_ack = ack;
  end

  typedef struct {
    logic        we;
    logic        rom;
    logic [23:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          lat;
    logic        exp_ram;
    logic        exp_rom;
  } vec_t;

  task automatic do_txn(input vec_t v);
    bit ok;
    ok = 0;
    @(negedge clk);
    we = v.we; rom_sel = v.rom; addr = v.a; wdata = v.wd; req = 1'b1;
    sb.push_back('{v.exp_rd, v.lat});
    @(posedge clk); #1;
    req = 1'b0;
    check("busy_after_accept", busy, 1);
    addr = 24'h3FFFFC; wdata = ~v.wd; we = ~v.we; rom_sel = ~v.rom;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk); #1;
      if (ack) ok = 1;
    end
    if (!ok) begin
      check("ack_timeout", 0, 1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  vec_t vecs[7];
  int   exp_acks = 0;

  initial begin
    bit ok;
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i] = '0;
      rom_mem[i] = '0;
    end
    ram_mem[4] = 32'hDEADBEEF;
    ram_mem[5] = 32'hA5A55A5A;
    rom_mem[0] = 32'hCAFEF00D;

    //            we    rom   addr        wdata          exp rdata      lat     ram   rom
    vecs[0] = '{1'b0, 1'b0, 24'h000010, 32'h0,        32'hDEADBEEF, LAT_RD, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 24'h000100, 32'h12345678, 32'hDEADBEEF, LAT_WR, 1'b1, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 24'h000100, 32'h0,        32'h12345678, LAT_RD, 1'b1, 1'b0};
    vecs[3] = '{1'b0, 1'b1, 24'h000000, 32'h0,        32'hCAFEF00D, LAT_RD, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 24'h000000, 32'hFFFFFFFF, 32'hCAFEF00D, 1,      1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 24'h000000, 32'h0,        32'hCAFEF00D, LAT_RD, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 24'h000014, 32'h0,        32'hA5A55A5A, LAT_RD, 1'b1, 1'b0};

    #1 reset = 1'b1;
    #2;
    check("rst_ram_csb", ram_csb, 1);
    check("rst_rom_csb", rom_csb, 1);
    check("rst_sclk", sclk, 0);
    check("rst_io_oe", io_oe, 0);
    check("rst_io_out", io_out, 0);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_rdata", rdata, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      saw_ram = 0; saw_rom = 0; dummy_z = 0; oe_err = 0;
      do_txn(vecs[i]);
      exp_acks++;
      check($sformatf("v%0d_ram_active", i), saw_ram, vecs[i].exp_ram);
      check($sformatf("v%0d_rom_active", i), saw_rom, vecs[i].exp_rom);
      if (vecs[i].exp_ram || vecs[i].exp_rom) begin
        check($sformatf("v%0d_cmd", i), cmd_cap, vecs[i].we ? 8'h38 : 8'hEB);
        check($sformatf("v%0d_addr", i), addr_cap, vecs[i].a);
        check($sformatf("v%0d_oe", i), oe_err, 0);
        if (vecs[i].we) check($sformatf("v%0d_wdata", i), wd_cap, vecs[i].wd);
        else check($sformatf("v%0d_dummy", i), dummy_z, 4);
      end
    end

    // Reset during the address phase of a RAM write.
    @(negedge clk);
    we = 1'b1; rom_sel = 1'b0; addr = 24'h000200; wdata = 32'h55AA55AA; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    ok = 0;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk); #1;
      if (n >= 10) ok = 1;
    end
    check("rst_mid_reach_addr", ok, 1);
    #1 reset = 1'b1;
    #1;
    check("rst_mid_ram_csb", ram_csb, 1);
    check("rst_mid_rom_csb", rom_csb, 1);
    check("rst_mid_io_oe", io_oe, 0);
    check("rst_mid_sclk", sclk, 0);
    check("rst_mid_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("rst_mid_ack", ack, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_no_write", ram_mem[128], 0);
    do_txn('{1'b0, 1'b0, 24'h000010, 32'h0, 32'hDEADBEEF, LAT_RD, 1'b1, 1'b0});
    exp_acks++;

    // Back-to-back with req held high; inputs scrambled during each transfer.
    @(negedge clk);
    we = 1'b0; rom_sel = 1'b0; addr = 24'h000010; req = 1'b1;
    sb.push_back('{32'hDEADBEEF, LAT_RD});
    sb.push_back('{32'hDEADBEEF, LAT_WR});
    sb.push_back('{32'h0BADF00D, LAT_RD});
    exp_acks += 3;
    for (int t = 0; t < 3; t++) begin
      ok = 0;
      for (int k = 0; k < 10 && !ok; k++) begin
        @(negedge clk); #1;
        ok = busy && !ack;
      end
      check("b2b_accept", ok, 1);
      if (t > 0) check("b2b_idle_gap", last_gap, 1);
      addr = 24'hABCDE0; wdata = 32'hFFFF0000; we = ~we; rom_sel = 1'b1;
      ok = 0;
      for (int k = 0; k < 200 && !ok; k++) begin
        @(negedge clk); #1;
        ok = ack;
      end
      check("b2b_ack", ok, 1);
      case (t)
        0: begin we = 1'b1; rom_sel = 1'b0; addr = 24'h000104; wdata = 32'h0BADF00D; end
        1: begin we = 1'b0; rom_sel = 1'b0; addr = 24'h000104; end
        default: req = 1'b0;
      endcase
    end
    repeat (4) @(negedge clk);

    check("ack_count", acks, exp_acks);
    check("scoreboard_empty", sb.size(), 0);
    check("bus_invariants", inv_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
